iir_zero_mac: RTL and testbench
===============================

# iir_zero_mac

Feed-forward (zero) section of the 2nd-order IIR filter. It sits directly upstream of the pole section and uses one shared 12x12 multiplier, time-multiplexed over three cycles, to compute Xout = b0·x[n] + b1·x[n-1] + b2·x[n-2]. The 26-bit result is summed with the pole-section output. Coefficients are Q10 (1024 = 1.0). The defaults give unity DC gain against the pole pair 1911/-986.

## Interface
Parameters:
- B0, default 25: signed 12-bit Q10 coefficient for x[n].
- B1, default 49: signed 12-bit Q10 coefficient for x[n-1].
- B2, default 25: signed 12-bit Q10 coefficient for x[n-2].

Ports (reset rst_n, asynchronous, active-high; clock clk):
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-high reset.
- Xin  in  12  signed input sample.
- din_valid  in  1  Xin is valid this cycle.
- din_ready  out  1  high when the block can accept a sample (state IDLE).
- Xout  out  26  signed numerator sum; holds its value until the next result.
- dout_valid  out  1  one-cycle pulse; Xout is new this cycle.
- overrun  out  1  sticky flag: a sample was presented while din_ready was low.

## Operation
- Delay line: x0, x1, x2, each 12-bit signed.
- Accumulator: acc, 26-bit signed.
- FSM states: IDLE, M0, M1, M2.
- IDLE, din_valid=1: x2<=x1, x1<=x0, x0<=Xin; next state M0.
- IDLE, din_valid=0: stay in IDLE; the delay line does not move.
- M0: acc <= B0·x0; next state M1.
- M1: acc <= acc + B1·x1; next state M2.
- M2: Xout <= acc + B2·x2; dout_valid <= 1; next state IDLE.
- Multiplier operand mux: (x0,B0) in M0, (x1,B1) in M1, (x2,B2) in M2.
- Product: 24-bit signed, sign-extended to 26 bits before adding.
- No overflow is possible: |sum| ≤ 2048·3·2047 < 2^25. No saturation, no truncation.
- din_ready = (state == IDLE), decoded combinationally from the state register.
- din_valid while din_ready=0: the sample is dropped, the delay line is unchanged, overrun <= 1. overrun stays high until reset.
- Reset values: state=IDLE, x0=x1=x2=0, acc=0, Xout=0, dout_valid=0, overrun=0, din_ready=1.
- Reset asserted mid-computation (any M state): everything clears immediately. No dout_valid is issued for the aborted sample.
- Reset released: the first accepted sample sees x1=x2=0.

## Timing
- Sample accepted at edge k. The block is in M0 at k, M1 at k+1, M2 at k+2.
- Xout updates and dout_valid rises at edge k+3. dout_valid falls at edge k+4.
- Latency: 3 clocks from the accepting edge to Xout valid.
- din_ready is low during the cycles after edges k, k+1 and k+2. It is high again in the same cycle dout_valid is high.
- Next sample can be accepted at edge k+4. Maximum throughput is 1 sample per 4 clocks.
- din_valid held high continuously: samples are accepted every 4th edge. The intermediate valids are dropped and set overrun.
- Downstream consumer: must latch Xout on dout_valid. Xout is stable until the next M2 edge.

## Test plan
- Reset: assert rst_n=1 for 2 cycles, then release. Required: Xout=0, dout_valid=0, overrun=0, din_ready=1.
- Impulse: Xin=1024 for one sample, then three samples of 0, spaced 4 clocks apart. Required: Xout = 25600, 50176, 25600, 0, each with a single-cycle dout_valid exactly 3 edges after acceptance.
- Step extremes, spaced 4 clocks apart:
  - Xin=2047 repeated: Xout = 51175, 151478, 202653, 202653.
  - Xin=-2048 repeated: Xout = -51200, -151552, -202752.
- Overrun: present din_valid on the edge after acceptance (state M0). Required: the sample is ignored, overrun=1 and stays set, and the result still reflects only the accepted sample.
- Continuous din_valid with Xin incrementing by 1 each cycle: only every 4th sample is accepted, overrun=1, and each Xout matches a golden model fed only the accepted samples.
- Mid-operation reset: accept Xin=1000 and assert reset during M1. Required: no dout_valid and Xout=0. After release, Xin=1000 gives Xout=25000 (x1, x2 cleared).

Source files
------------

// File: rtl/iir_zero_mac.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iir_zero_mac: IIR zero section, b0*x[n] + b1*x[n-1] + b2*x[n-2] on one
// shared 12x12 multiplier over three cycles.  Revision: 1.0
// ---------------------------------------------------------------------------
module iir_zero_mac #(
  parameter logic signed [11:0] B0 = 12'sd25,
  parameter logic signed [11:0] B1 = 12'sd49,
  parameter logic signed [11:0] B2 = 12'sd25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] Xin,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [25:0] Xout,
  output logic        dout_valid,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE = 2'd0, M0 = 2'd1, M1 = 2'd2, M2 = 2'd3} state_t;

  state_t             state;
  state_t             state_nxt;
  logic signed [11:0] x0, x1, x2;
  logic signed [25:0] acc;
  logic signed [11:0] mul_a, mul_b;
  logic signed [23:0] prod;
  logic signed [25:0] prod_ext;

  assign din_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (din_valid) state_nxt = M0;
      M0:      state_nxt = M1;
      M1:      state_nxt = M2;
      M2:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand mux for the shared multiplier; IDLE selection is a don't-care.
  always_comb begin
    mul_a = x0;
    mul_b = B0;
    case (state)
      M1:      begin mul_a = x1; mul_b = B1; end
      M2:      begin mul_a = x2; mul_b = B2; end
      default: begin mul_a = x0; mul_b = B0; end
    endcase
  end

  assign prod     = 24'(mul_a) * 24'(mul_b);
  assign prod_ext = {{2{prod[23]}}, prod};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      x0         <= '0;
      x1         <= '0;
      x2         <= '0;
      acc        <= '0;
      Xout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (din_valid && !din_ready) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (din_valid) begin
            x2 <= x1;
            x1 <= x0;
            x0 <= $signed(Xin);
          end
        end
        M0: acc <= prod_ext;
        M1: acc <= acc + prod_ext;
        M2: begin
          Xout       <= acc + prod_ext;
          dout_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iir_zero_mac.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_iir_zero_mac: randomized and directed bench against a behavioural model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_iir_zero_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] Xin = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [25:0] Xout;
  logic        dout_valid;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  localparam int C_B0 = 25;
  localparam int C_B1 = 49;
  localparam int C_B2 = 25;

  iir_zero_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Xin       (Xin),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .Xout      (Xout),
    .dout_valid(dout_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Behavioural model: history of accepted samples and a busy countdown.
  int h0, h1, h2;
  int busy;
  int exp_xout;
  bit exp_dv, exp_ov;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      h0 = 0; h1 = 0; h2 = 0;
      busy = 0; exp_xout = 0; exp_dv = 0; exp_ov = 0;
    end else begin
      exp_dv = 0;
      if (busy == 0) begin
        if (din_valid) begin
          h2 = h1; h1 = h0; h0 = int'($signed(Xin));
          busy = 3;
        end
      end else begin
        if (din_valid) exp_ov = 1;
        busy = busy - 1;
        if (busy == 0) begin
          exp_xout = C_B0 * h0 + C_B1 * h1 + C_B2 * h2;
          exp_dv = 1;
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    checks++;
    if (int'($signed(Xout)) != exp_xout) begin
      errors++;
      $display("FAIL model_xout t=%0t: got %0d required %0d", $time, $signed(Xout), exp_xout);
    end
    checks++;
    if (dout_valid !== exp_dv) begin
      errors++;
      $display("FAIL model_dv t=%0t: got %b required %b", $time, dout_valid, exp_dv);
    end
    checks++;
    if (din_ready !== (busy == 0)) begin
      errors++;
      $display("FAIL model_ready t=%0t: got %b required %b", $time, din_ready, busy == 0);
    end
    checks++;
    if (overrun !== exp_ov) begin
      errors++;
      $display("FAIL model_ov t=%0t: got %b required %b", $time, overrun, exp_ov);
    end
  end

  task automatic check_lit(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  // Present one sample, then require the result exactly 3 edges later.
  task automatic send(input int v, input int req, input string nm);
    int n;
    @(negedge clk);
    din_valid = 1'b1;
    Xin = 12'(v);
    @(negedge clk);
    din_valid = 1'b0;
    n = 0;
    #1;
    while (!dout_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!dout_valid || n != 3 || int'($signed(Xout)) != req) begin
      errors++;
      $display("FAIL %s: Xout=%0d dv=%b latency=%0d required Xout=%0d latency=3",
               nm, $signed(Xout), dout_valid, n, req);
    end
  endtask

  initial begin
    int seen;
    // Reset state
    do_reset();
    #1;
    check_lit("reset_xout", int'($signed(Xout)), 0);
    check_lit("reset_dv", int'(dout_valid), 0);
    check_lit("reset_ov", int'(overrun), 0);
    check_lit("reset_ready", int'(din_ready), 1);

    // Impulse response
    send(1024, 25600, "imp0");
    send(0, 50176, "imp1");
    send(0, 25600, "imp2");
    send(0, 0, "imp3");

    // Step extremes
    do_reset();
    send(2047, 51175, "pos0");
    send(2047, 151478, "pos1");
    send(2047, 202653, "pos2");
    send(2047, 202653, "pos3");
    do_reset();
    send(-2048, -51200, "neg0");
    send(-2048, -151552, "neg1");
    send(-2048, -202752, "neg2");

    // Overrun: second valid arrives while in M0
    do_reset();
    @(negedge clk);
    din_valid = 1'b1; Xin = 12'd100;
    @(negedge clk);
    Xin = 12'd500;
    @(negedge clk);
    din_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (dout_valid) begin
        seen++;
        check_lit("ovr_xout", int'($signed(Xout)), 2500);
      end
      @(negedge clk);
    end
    check_lit("ovr_pulses", seen, 1);
    check_lit("ovr_flag", int'(overrun), 1);
    send(0, 4900, "ovr_next");
    check_lit("ovr_sticky", int'(overrun), 1);

    // Continuous valid with incrementing input
    do_reset();
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      din_valid = 1'b1;
      Xin = 12'(i + 1);
    end
    @(negedge clk);
    din_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check_lit("cont_ov", int'(overrun), 1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      din_valid = ($urandom_range(0, 3) != 0);
      Xin = 12'($urandom);
    end
    @(negedge clk);
    din_valid = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during M1 aborts the sample
    do_reset();
    @(negedge clk);
    din_valid = 1'b1; Xin = 12'd1000;
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (dout_valid) seen++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (dout_valid) seen++;
      @(negedge clk);
    end
    check_lit("abort_no_dv", seen, 0);
    #1;
    check_lit("abort_xout", int'($signed(Xout)), 0);
    send(1000, 25000, "after_abort");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
